wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback-side producer for the 32x32 register file write port (RegWrite/WB_Rdaddr/WB_Rddata).
//  Merges two result sources: the ALU pipe (priority, 1-cycle latency) and load responses
//  (buffered in a FIFO). Drives a registered single-port write into the register file.
//  Exports a pending-load mask so hazard logic can stall readers of not-yet-written loads.
// PARAMETERS
//  FIFO_DEPTH  4  load FIFO entries; power of 2, >=2
//  MAX_WAIT    8  blocked cycles tolerated at FIFO head before forcing a load write; >=1
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  alu_valid    in   1   ALU result valid
//  alu_ready    out  1   ALU result accepted when alu_valid&&alu_ready
//  alu_rd       in   5   ALU destination register
//  alu_data     in   32  ALU result
//  ld_valid     in   1   load response valid
//  ld_ready     out  1   load response accepted when ld_valid&&ld_ready
//  ld_rd        in   5   load destination register
//  ld_data      in   32  load data
//  RegWrite     out  1   register file write enable (registered)
//  WB_Rdaddr    out  5   register file write address (registered)
//  WB_Rddata    out  32  register file write data (registered)
//  ld_pend_mask out  32  bit i=1: a load to x[i] is queued or in the output stage
// BEHAVIOUR
//  Reset (sync, rst high at posedge): RegWrite=0, WB_Rdaddr=0, WB_Rddata=0, FIFO empty,
//   wait counter=0, state=NORMAL, output-stage-is-load flag=0; ld_pend_mask=0 the next cycle.
//   Reset mid-operation drops all queued loads and any write in the output stage.
//  ld_ready = !full (no simultaneous-dequeue bypass). alu_ready = (state==NORMAL).
//  Load enqueue on ld_valid&&ld_ready; ld_rd==0 is accepted but discarded (not stored).
//  Selection per cycle, first match wins:
//   1) state==DRAIN -> dequeue FIFO head to output
//   2) alu_valid && alu_rd!=0 -> ALU result to output
//   3) FIFO non-empty -> dequeue head to output
//   4) no write
//  ALU accepted with alu_rd==0: handshake completes, no write, slot free for rule 3.
//  Output stage: on a selection, next cycle RegWrite=1, WB_Rdaddr/WB_Rddata=selected;
//   otherwise RegWrite=0 and WB_Rdaddr/WB_Rddata hold. RegWrite never asserted with WB_Rdaddr==0.
//  Latency: ALU accept at cycle N -> RegWrite at N+1. Load into empty FIFO at N -> earliest
//   dequeue at N+1, RegWrite at N+2 (no enqueue->output bypass). Loads write in arrival order.
//  FSM NORMAL/DRAIN with wait counter (width clog2(MAX_WAIT)+1):
//   NORMAL: FIFO non-empty and head not dequeued -> counter+1; dequeue or empty -> counter=0.
//    If blocked and counter==MAX_WAIT-1 -> DRAIN next cycle, counter=0.
//   DRAIN: lasts exactly one cycle; head dequeued, alu_ready=0; -> NORMAL.
//   DRAIN is only entered with FIFO non-empty, so a head is always present.
//  ld_pend_mask: OR over valid FIFO entries of onehot(rd), plus onehot(WB_Rdaddr) when the
//   output stage holds a load write; bit 0 always 0. Derived from current registered state.
//  FIFO: pointers one bit wider than log2(FIFO_DEPTH); wrap is by natural overflow.
//   full = MSBs differ and low bits equal; empty = pointers equal.
//  WAW between the ALU and loads is not resolved here; issue logic uses ld_pend_mask.
// TESTING
//  1 reset: rst 2 cycles -> RegWrite=0, WB_Rdaddr=0, ld_ready=1, alu_ready=1, ld_pend_mask=0
//  2 ALU: alu_valid rd=5 data=32'hDEADBEEF at N -> N+1 RegWrite=1, WB_Rdaddr=5, WB_Rddata=DEADBEEF
//  3 load idle: ld rd=7 data=32'h1234 at N -> mask[7]=1 at N+1,N+2; RegWrite rd=7 at N+2; mask[7]=0 at N+3
//  4 full: ALU rd=1 every cycle, 4 loads rd=10..13 -> ld_ready=0 after 4th accept; 5th held until starvation drain frees a slot
//  5 starve: ALU rd=3 continuous, 1 load rd=9 -> after 8 blocked cycles, one cycle alu_ready=0 and x9 written; ALU resumes next cycle
//  6 x0: ld rd=0 -> accepted, no mask bit, no write; ALU rd=0 with queued load rd=4 -> x4 written next cycle
//  7 reset mid-op: 3 loads queued, rst 1 cycle -> FIFO empty, mask=0, no further RegWrite for those loads

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results (priority) and FIFO-buffered load responses into a
// registered register-file write port, with a starvation drain and a pending-load mask.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        RegWrite,
    output logic [4:0]  WB_Rdaddr,
    output logic [31:0] WB_Rddata,
    output logic [31:0] ld_pend_mask
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_WAIT) + 1;

    localparam logic [0:0] S_NORMAL = 1'b0;
    localparam logic [0:0] S_DRAIN  = 1'b1;

    logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
    logic [31:0]   r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we, r_out_is_ld;
    logic [4:0]    r_addr;
    logic [31:0]   r_data;

    logic          w_full, w_empty, w_enq, w_deq, w_alu_sel, w_drain;
    logic [PW-1:0] w_count;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_mask;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_count   = r_wptr - r_rptr;
    assign ld_ready  = !w_full;
    assign alu_ready = (r_state == S_NORMAL);
    assign w_drain   = (r_state == S_DRAIN);

    // x0 loads complete their handshake but never occupy a slot
    assign w_enq     = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign w_alu_sel = !w_drain && alu_valid && (alu_rd != 5'd0);
    assign w_deq     = w_drain || (!w_alu_sel && !w_empty);

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_rd[r_wptr[AW-1:0]]   <= ld_rd;
            r_fifo_data[r_wptr[AW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_state     <= S_NORMAL;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_out_is_ld <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + PW'(1);
            if (w_deq) r_rptr <= r_rptr + PW'(1);

            if (w_alu_sel) begin
                r_we        <= 1'b1;
                r_out_is_ld <= 1'b0;
                r_addr      <= alu_rd;
                r_data      <= alu_data;
            end else if (w_deq) begin
                r_we        <= 1'b1;
                r_out_is_ld <= 1'b1;
                r_addr      <= r_fifo_rd[r_rptr[AW-1:0]];
                r_data      <= r_fifo_data[r_rptr[AW-1:0]];
            end else begin
                r_we        <= 1'b0;
                r_out_is_ld <= 1'b0;
            end

            // Head blocked by ALU traffic for MAX_WAIT cycles forces a one-cycle drain
            if (w_drain) begin
                r_state <= S_NORMAL;
                r_cnt   <= '0;
            end else if (!w_empty && !w_deq) begin
                if (r_cnt == CW'(MAX_WAIT - 1)) begin
                    r_state <= S_DRAIN;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        w_idx  = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            w_idx = r_rptr[AW-1:0] + AW'(k);
            if (PW'(k) < w_count) w_mask[r_fifo_rd[w_idx]] = 1'b1;
        end
        if (r_out_is_ld) w_mask[r_addr] = 1'b1;
        w_mask[0] = 1'b0;
    end

    assign ld_pend_mask = w_mask;
    assign RegWrite     = r_we;
    assign WB_Rdaddr    = r_addr;
    assign WB_Rddata    = r_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + randomized bench for wb_arbiter against a queue-based writeback model.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int MAXW  = 8;

    logic        clk = 1'b0;
    logic        rst, alu_valid, ld_valid;
    logic [4:0]  alu_rd, ld_rd;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, ld_ready, RegWrite;
    logic [4:0]  WB_Rdaddr;
    logic [31:0] WB_Rddata, ld_pend_mask;

    always #5 clk = ~clk;

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .RegWrite(RegWrite), .WB_Rdaddr(WB_Rdaddr), .WB_Rddata(WB_Rddata),
        .ld_pend_mask(ld_pend_mask)
    );

    typedef struct { logic [4:0] rd; logic [31:0] d; } ld_t;
    ld_t         q[$];
    logic        m_we, m_out_ld, m_drain;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_blocked;
    bit          checking = 0;
    int          nvec = 0, nerr = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m = '0;
        foreach (q[i]) m |= 32'h1 << q[i].rd;
        if (m_out_ld) m |= 32'h1 << m_addr;
        return m & ~32'h1;
    endfunction

    // Called after a negedge: compare, drive, advance model, cross the posedge.
    task automatic step(logic r, logic av, logic [4:0] ard, logic [31:0] ad,
                        logic lv, logic [4:0] lrd, logic [31:0] ldd);
        bit pend, deq, asel, lrdy;
        ld_t e;
        if (checking) begin
            chk("RegWrite", 32'(RegWrite), 32'(m_we));
            chk("WB_Rdaddr", 32'(WB_Rdaddr), 32'(m_addr));
            chk("WB_Rddata", WB_Rddata, m_data);
            chk("alu_ready", 32'(alu_ready), 32'(!m_drain));
            chk("ld_ready", 32'(ld_ready), 32'(q.size() < DEPTH));
            chk("ld_pend_mask", ld_pend_mask, exp_mask());
        end
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_data = ldd;
        if (r) begin
            q.delete();
            m_we = 0; m_out_ld = 0; m_drain = 0; m_addr = 0; m_data = 0; m_blocked = 0;
        end else begin
            pend = q.size() > 0;
            lrdy = q.size() < DEPTH;
            asel = !m_drain && av && ard != 0;
            deq  = m_drain || (!asel && pend);
            if (asel) begin
                m_we = 1; m_out_ld = 0; m_addr = ard; m_data = ad;
            end else if (deq) begin
                e = q.pop_front();
                m_we = 1; m_out_ld = 1; m_addr = e.rd; m_data = e.d;
            end else begin
                m_we = 0; m_out_ld = 0;
            end
            if (lv && lrdy && lrd != 0) q.push_back('{lrd, ldd});
            if (m_drain) begin
                m_drain = 0; m_blocked = 0;
            end else if (pend && !deq) begin
                m_blocked++;
                if (m_blocked == MAXW) begin m_drain = 1; m_blocked = 0; end
            end else m_blocked = 0;
        end
        @(posedge clk);
        @(negedge clk);
        checking = 1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int alu_low;
        @(negedge clk);
        // reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_we", 32'(RegWrite), 32'h0);
        chk("rst_ldrdy", 32'(ld_ready), 32'h1);
        chk("rst_alurdy", 32'(alu_ready), 32'h1);
        chk("rst_mask", ld_pend_mask, 32'h0);
        // ALU write, one-cycle latency
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        chk("alu_we", 32'(RegWrite), 32'h1);
        chk("alu_addr", 32'(WB_Rdaddr), 32'd5);
        chk("alu_data", WB_Rddata, 32'hDEADBEEF);
        // load into idle block
        step(0, 0, 0, 0, 1, 7, 32'h1234);
        chk("ld_mask1", ld_pend_mask, 32'h80);
        idle(1);
        chk("ld_mask2", ld_pend_mask, 32'h80);
        chk("ld_we", 32'(RegWrite), 32'h1);
        chk("ld_data", WB_Rddata, 32'h1234);
        idle(1);
        chk("ld_mask3", ld_pend_mask, 32'h0);
        // fill under ALU pressure; the fifth load waits for a drain
        for (int i = 0; i < 4; i++) step(0, 1, 1, 32'(100 + i), 1, 5'(10 + i), 32'(200 + i));
        chk("full_ldrdy", 32'(ld_ready), 32'h0);
        for (int i = 0; i < 14; i++) step(0, 1, 1, 32'(300 + i), 1, 14, 32'h14);
        idle(8);
        // starvation of a single load behind continuous ALU traffic
        step(0, 1, 3, 32'h30, 1, 9, 32'h99);
        alu_low = 0;
        for (int i = 0; i < 12; i++) begin
            if (!alu_ready) alu_low++;
            step(0, 1, 3, 32'(i), 0, 0, 0);
        end
        chk("starve_drains", 32'(alu_low), 32'd1);
        idle(3);
        // x0 handling
        step(0, 0, 0, 0, 1, 0, 32'h5A5A);
        chk("x0_mask", ld_pend_mask, 32'h0);
        idle(1);
        chk("x0_nowrite", 32'(RegWrite), 32'h0);
        step(0, 1, 2, 32'h22, 1, 4, 32'h44);
        step(0, 1, 0, 32'h77, 0, 0, 0);
        chk("x0alu_addr", 32'(WB_Rdaddr), 32'd4);
        chk("x0alu_data", WB_Rddata, 32'h44);
        idle(2);
        // reset mid-operation with loads queued
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'(i), 1, 5'(20 + i), 32'(i));
        step(1, 0, 0, 0, 0, 0, 0);
        chk("midrst_mask", ld_pend_mask, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_we", 32'(RegWrite), 32'h0);
            step(0, 0, 0, 0, 0, 0, 0);
        end
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, av, lv;
            logic [4:0] ard, lrd;
            r   = ($urandom_range(0, 199) == 0);
            av  = ($urandom_range(0, 99) < 75);
            lv  = ($urandom_range(0, 99) < 45);
            ard = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            lrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            step(r, av, ard, $urandom, lv, lrd, $urandom);
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
